mda_power_sequencer: RTL and testbench

MDA_POWER_SEQUENCER -- requirements
Module: mda_power_sequencer

---
 rtl/mda_power_sequencer_if.sv | 25 ++
 rtl/mda_power_sequencer.sv | 159 +++++++++++++++
 tb/tb_mda_power_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mda_power_sequencer_if.sv
// Signal bundle between the power sequencer and the surrounding system:
// arming/fault inputs, raw motor pins in, gated motor pins and status out.
interface mda_power_sequencer_if #(
  parameter int NUM_MOTORS = 8
);
  logic                    kill_sw;
  logic                    leak;
  logic                    clear_fault;
  logic [4*NUM_MOTORS-1:0] motor_gpio_in;
  logic [4*NUM_MOTORS-1:0] motor_gpio_out;
  logic                    imu_reset;
  logic [NUM_MOTORS-1:0]   motor_en;
  logic [2:0]              state;
  logic                    fault;

  modport master (
    output kill_sw, leak, clear_fault, motor_gpio_in,
    input  motor_gpio_out, imu_reset, motor_en, state, fault
  );

  modport slave (
    input  kill_sw, leak, clear_fault, motor_gpio_in,
    output motor_gpio_out, imu_reset, motor_en, state, fault
  );
endinterface

// File: rtl/mda_power_sequencer.sv
// Power-up sequencer: IMU reset pulse, then staggered motor-channel enables,
// with kill-switch shutdown and a latched leak fault.
module mda_power_sequencer #(
  parameter int NUM_MOTORS     = 8,
  parameter int IMU_RST_CYCLES = 100,
  parameter int STAGGER_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mda_power_sequencer_if.slave bus
);

  localparam int MAX_CYC = (IMU_RST_CYCLES > STAGGER_CYCLES) ? IMU_RST_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int CH_W    = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;

  localparam logic [CNT_W-1:0] IMU_LOAD = CNT_W'(IMU_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STG_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  // Channel index just before the last one; reaching it means the next enable completes the ramp.
  localparam logic [CH_W-1:0]  CH_PEN   = CH_W'(NUM_MOTORS - 2);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    IMU_RST = 3'd1,
    STAGGER = 3'd2,
    RUN     = 3'd3,
    FAULT   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [NUM_MOTORS-1:0] motor_en_q, motor_en_d;
  logic                  imu_reset_q, imu_reset_d;
  logic                  fault_q, fault_d;
  logic                  kill_meta_q, kill_meta_d, kill_sync_q, kill_sync_d;
  logic                  leak_meta_q, leak_meta_d, leak_sync_q, leak_sync_d;
  logic [4*NUM_MOTORS-1:0] gpio_gated;

  always_comb begin
    kill_meta_d = bus.kill_sw;
    kill_sync_d = kill_meta_q;
    leak_meta_d = bus.leak;
    leak_sync_d = leak_meta_q;

    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    motor_en_d  = motor_en_q;
    imu_reset_d = imu_reset_q;
    fault_d     = fault_q;

    // A leak overrides everything, including a simultaneous kill.
    if (leak_sync_q) begin
      state_d     = FAULT;
      fault_d     = 1'b1;
      motor_en_d  = '0;
      imu_reset_d = 1'b0;
      cnt_d       = '0;
      ch_d        = '0;
    end else begin
      case (state_q)
        OFF: begin
          if (kill_sync_q) begin
            state_d     = IMU_RST;
            cnt_d       = IMU_LOAD;
            imu_reset_d = 1'b1;
          end
        end
        IMU_RST, STAGGER, RUN: begin
          if (!kill_sync_q) begin
            state_d     = OFF;
            motor_en_d  = '0;
            imu_reset_d = 1'b0;
            cnt_d       = '0;
            ch_d        = '0;
          end else if (state_q == IMU_RST) begin
            if (cnt_q == '0) begin
              imu_reset_d = 1'b0;
              motor_en_d  = NUM_MOTORS'(1);
              ch_d        = '0;
              cnt_d       = (NUM_MOTORS == 1) ? '0 : STG_LOAD;
              state_d     = (NUM_MOTORS == 1) ? RUN : STAGGER;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end else if (state_q == STAGGER) begin
            if (cnt_q == '0) begin
              motor_en_d = (motor_en_q << 1) | NUM_MOTORS'(1);
              ch_d       = ch_q + 1'b1;
              if (ch_q == CH_PEN) begin
                state_d = RUN;
                cnt_d   = '0;
              end else begin
                cnt_d = STG_LOAD;
              end
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        FAULT: begin
          if (bus.clear_fault && !kill_sync_q) begin
            state_d = OFF;
            fault_d = 1'b0;
          end
        end
        default: begin
          state_d     = OFF;
          motor_en_d  = '0;
          imu_reset_d = 1'b0;
          cnt_d       = '0;
          ch_d        = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= OFF;
      cnt_q       <= '0;
      ch_q        <= '0;
      motor_en_q  <= '0;
      imu_reset_q <= 1'b0;
      fault_q     <= 1'b0;
      kill_meta_q <= 1'b0;
      kill_sync_q <= 1'b0;
      leak_meta_q <= 1'b0;
      leak_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      motor_en_q  <= motor_en_d;
      imu_reset_q <= imu_reset_d;
      fault_q     <= fault_d;
      kill_meta_q <= kill_meta_d;
      kill_sync_q <= kill_sync_d;
      leak_meta_q <= leak_meta_d;
      leak_sync_q <= leak_sync_d;
    end
  end

  // Pin gating uses the registered enables directly so it adds no latency.
  always_comb begin
    gpio_gated = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (motor_en_q[i]) gpio_gated[4*i +: 4] = bus.motor_gpio_in[4*i +: 4];
    end
  end

  assign bus.motor_gpio_out = gpio_gated;
  assign bus.imu_reset      = imu_reset_q;
  assign bus.motor_en       = motor_en_q;
  assign bus.state          = state_q;
  assign bus.fault          = fault_q;

endmodule

// File: tb/tb_mda_power_sequencer.sv
// Bench for mda_power_sequencer: elapsed-time behavioural model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mda_power_sequencer;
  localparam int NM  = 8;
  localparam int IMU = 4;
  localparam int STG = 3;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  mda_power_sequencer_if #(.NUM_MOTORS(NM)) bus();

  mda_power_sequencer #(
    .NUM_MOTORS(NM), .IMU_RST_CYCLES(IMU), .STAGGER_CYCLES(STG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  // Model: inputs seen two edges late; state plus time spent in the current phase.
  int m_state, m_t;
  bit m_fault;
  bit hk1, hk2, hl1, hl2, uk, ul;

  initial begin
    m_state = 0; m_t = 0; m_fault = 0;
    hk1 = 0; hk2 = 0; hl1 = 0; hl2 = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_state = 0; m_t = 0; m_fault = 0;
        hk1 = 0; hk2 = 0; hl1 = 0; hl2 = 0;
      end else begin
        uk = hk2; ul = hl2;
        hk2 = hk1; hl2 = hl1;
        hk1 = bus.kill_sw; hl1 = bus.leak;
        if (ul) begin
          m_state = 4; m_fault = 1; m_t = 0;
        end else begin
          case (m_state)
            0: if (uk) begin m_state = 1; m_t = 0; end
            1: if (!uk) m_state = 0;
               else if (m_t == IMU - 1) begin m_state = 2; m_t = 0; end
               else m_t++;
            2: if (!uk) m_state = 0;
               else begin
                 m_t++;
                 if (m_t == (NM - 1) * STG) m_state = 3;
               end
            3: if (!uk) m_state = 0;
            default: if (bus.clear_fault && !uk) begin m_state = 0; m_fault = 0; end
          endcase
        end
      end
    end
  end

  function automatic logic [NM-1:0] exp_en();
    int k;
    if (m_state == 3) return '1;
    if (m_state != 2) return '0;
    k = m_t / STG + 1;
    return NM'((32'd1 << k) - 1);
  endfunction

  function automatic logic [4*NM-1:0] exp_gpio(input logic [NM-1:0] en);
    logic [4*NM-1:0] g;
    g = '0;
    for (int i = 0; i < NM; i++) if (en[i]) g[4*i +: 4] = bus.motor_gpio_in[4*i +: 4];
    return g;
  endfunction

  initial begin
    logic [NM-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      e = exp_en();
      chk("mdl_state", 32'(bus.state), 32'(m_state));
      chk("mdl_en", 32'(bus.motor_en), 32'(e));
      chk("mdl_imu", 32'(bus.imu_reset), 32'(m_state == 1));
      chk("mdl_fault", 32'(bus.fault), 32'(m_fault));
      chk("mdl_gpio", bus.motor_gpio_out, exp_gpio(e));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_en(input logic [NM-1:0] v, input int budget);
    int k;
    k = 0;
    while (bus.motor_en !== v && k < budget) begin @(negedge clk); k++; end
    chk("wait_en", 32'(bus.motor_en), 32'(v));
  endtask

  task automatic wait_state(input logic [2:0] v, input int budget);
    int k;
    k = 0;
    while (bus.state !== v && k < budget) begin @(negedge clk); k++; end
    chk("wait_state", 32'(bus.state), 32'(v));
  endtask

  initial begin
    int hi;
    reset_n = 1'b0;
    bus.kill_sw = 1'b0; bus.leak = 1'b0; bus.clear_fault = 1'b0;
    bus.motor_gpio_in = '0;
    tick(3);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_en", 32'(bus.motor_en), 32'd0);
    chk("rst_imu", 32'(bus.imu_reset), 32'd0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Arm and walk the full sequence.
    bus.motor_gpio_in = 32'h5A5A5A5A;
    bus.kill_sw = 1'b1;
    tick(2);
    chk("arm_state_early", 32'(bus.state), 32'd0);
    tick(1);
    chk("arm_state", 32'(bus.state), 32'd1);
    chk("arm_imu", 32'(bus.imu_reset), 32'd1);
    tick(3);
    chk("imu_last", 32'(bus.imu_reset), 32'd1);
    tick(1);
    chk("imu_done", 32'(bus.imu_reset), 32'd0);
    chk("stg_state", 32'(bus.state), 32'd2);
    chk("stg_en1", 32'(bus.motor_en), 32'h01);
    tick(3);
    chk("stg_en3", 32'(bus.motor_en), 32'h03);
    chk("stg_gpio", bus.motor_gpio_out, 32'h0000005A);
    tick(17);
    chk("stg_en7f", 32'(bus.motor_en), 32'h7F);
    chk("stg_state7f", 32'(bus.state), 32'd2);
    tick(1);
    chk("run_en", 32'(bus.motor_en), 32'hFF);
    chk("run_state", 32'(bus.state), 32'd3);

    bus.motor_gpio_in = 32'hAAAAAAAA;
    tick(1);
    chk("run_gpio", bus.motor_gpio_out, 32'hAAAAAAAA);
    bus.kill_sw = 1'b0;
    tick(2);
    chk("kill_pending", 32'(bus.state), 32'd3);
    tick(1);
    chk("kill_state", 32'(bus.state), 32'd0);
    chk("kill_gpio", bus.motor_gpio_out, 32'd0);

    // Leak mid-ramp, then a clear while still armed.
    bus.kill_sw = 1'b1;
    wait_en(8'h07, 40);
    bus.leak = 1'b1;
    tick(2);
    chk("leak_pending", 32'(bus.motor_en), 32'h07);
    tick(1);
    chk("leak_state", 32'(bus.state), 32'd4);
    chk("leak_fault", 32'(bus.fault), 32'd1);
    chk("leak_en", 32'(bus.motor_en), 32'h00);
    bus.leak = 1'b0;
    bus.clear_fault = 1'b1;
    tick(4);
    chk("clr_armed", 32'(bus.state), 32'd4);
    bus.clear_fault = 1'b0;

    // Proper clear, then re-arm and count the IMU pulse.
    bus.kill_sw = 1'b0;
    tick(3);
    bus.clear_fault = 1'b1;
    tick(1);
    bus.clear_fault = 1'b0;
    chk("clr_state", 32'(bus.state), 32'd0);
    chk("clr_fault", 32'(bus.fault), 32'd0);
    bus.kill_sw = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.imu_reset === 1'b1) hi++;
    end
    chk("rearm_imu_width", 32'(hi), 32'd4);

    // Asynchronous reset mid-ramp with kill held high.
    wait_en(8'h0F, 60);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_en", 32'(bus.motor_en), 32'h00);
    chk("arst_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);
    chk("rel_state_early", 32'(bus.state), 32'd0);
    tick(1);
    chk("rel_state", 32'(bus.state), 32'd1);
    wait_state(3'd3, 60);
    chk("rel_run_en", 32'(bus.motor_en), 32'hFF);

    // Leak and kill-off together in RUN: fault wins.
    bus.leak = 1'b1;
    bus.kill_sw = 1'b0;
    tick(3);
    chk("both_state", 32'(bus.state), 32'd4);
    chk("both_fault", 32'(bus.fault), 32'd1);
    bus.leak = 1'b0;
    tick(3);
    bus.clear_fault = 1'b1;
    tick(1);
    bus.clear_fault = 1'b0;
    chk("end_state", 32'(bus.state), 32'd0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
